// File: rtl/ql_bus_master_if.sv
// rtl/ql_bus_master_if.sv - request-side and expansion-bus signals of the QL bus initiator
interface ql_bus_master_if #(
    parameter int ADDR_W = 20
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic              ack;
    logic              err;
    logic              busy;
    logic [ADDR_W-1:0] address;
    logic              asl;
    logic              dsl;
    logic              rdwl;
    logic [7:0]        data_out;
    logic              data_oe;
    logic [7:0]        data_in;
    logic              dtackl;

    modport master (
        input  req, we, addr, wdata, data_in, dtackl,
        output rdata, ack, err, busy, address, asl, dsl, rdwl, data_out, data_oe
    );

    modport slave (
        output req, we, addr, wdata, data_in, dtackl,
        input  rdata, ack, err, busy, address, asl, dsl, rdwl, data_out, data_oe
    );
endinterface

// File: rtl/ql_bus_master.sv
// rtl/ql_bus_master.sv - 68008-style expansion-bus cycle generator; QL_BUS_TIMEOUT_EN adds a dtack timeout
module ql_bus_master #(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstl,
    ql_bus_master_if.master     bus
);
    typedef enum logic [2:0] {
        IDLE, S_ADDR, S_AS, S_DS, S_LATCH, S_END
    } state_t;

    state_t            state_q, state_d;
    logic              dtack_meta_q, dtack_s_q;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        data_out_q, data_out_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              rdwl_q, rdwl_d;
    logic              asl_q, asl_d;
    logic              dsl_q, dsl_d;
    logic              data_oe_q, data_oe_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              expire;

`ifdef QL_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign expire  = (cnt_inc == CNT_W'(TIMEOUT));

    // Restarts on every state change, so S_DS and S_END each get a full window.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_DS || state_q == S_END)
            cnt_d = cnt_inc;
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign expire = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        data_out_d = data_out_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        rdwl_d     = rdwl_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    address_d  = bus.addr;
                    data_out_d = bus.wdata;
                    we_d       = bus.we;
                    rdwl_d     = ~bus.we;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: state_d = S_AS;
            S_AS:   state_d = S_DS;
            S_DS: begin
                if (!dtack_s_q) begin
                    state_d = S_LATCH;
                end else if (expire) begin
                    state_d = S_END;
                    err_d   = 1'b1;
                end
            end
            S_LATCH: begin
                if (!we_q)
                    rdata_d = bus.data_in;
                state_d = S_END;
            end
            S_END: begin
                if (dtack_s_q || expire) begin
                    state_d = IDLE;
                    rdwl_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they leave the flops glitch-free.
        asl_d     = !(state_d inside {S_AS, S_DS, S_LATCH});
        dsl_d     = !(state_d inside {S_DS, S_LATCH});
        data_oe_d = we_d && (state_d inside {S_ADDR, S_AS, S_DS, S_LATCH});
        busy_d    = (state_d != IDLE);
        ack_d     = (state_d == S_END) && (state_q != S_END);
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state_q      <= IDLE;
            dtack_meta_q <= 1'b1;
            dtack_s_q    <= 1'b1;
            address_q    <= '0;
            data_out_q   <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            rdwl_q       <= 1'b1;
            asl_q        <= 1'b1;
            dsl_q        <= 1'b1;
            data_oe_q    <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dtack_meta_q <= bus.dtackl;
            dtack_s_q    <= dtack_meta_q;
            address_q    <= address_d;
            data_out_q   <= data_out_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            rdwl_q       <= rdwl_d;
            asl_q        <= asl_d;
            dsl_q        <= dsl_d;
            data_oe_q    <= data_oe_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.address  = address_q;
    assign bus.data_out = data_out_q;
    assign bus.rdata    = rdata_q;
    assign bus.rdwl     = rdwl_q;
    assign bus.asl      = asl_q;
    assign bus.dsl      = dsl_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
endmodule
